datapoint_memory_arbiter: RTL and testbench

DATAPOINT_MEMORY_ARBITER -- requirements
Module: datapoint_memory_arbiter

---
 rtl/datapoint_memory_arbiter.sv | 87 ++++++++
 tb/tb_datapoint_memory_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapoint_memory_arbiter.sv
// datapoint_memory_arbiter: shares one datapoint memory port between host single-word writes and two neuron burst readers
// Ports: clock, reset (async, active-low); io_wr*: host write request; io_rd0*/io_rd1*: burst read request plus
// response strobes; io_rdRespData: shared response word; io_busy: not IDLE; io_mem_*: memory port, 1-cycle read latency.
module datapoint_memory_arbiter #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 10,
  parameter int LEN_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_wrReqValid,
  output logic              io_wrReqReady,
  input  logic [ADDR_W-1:0] io_wrAddr,
  input  logic [DATA_W-1:0] io_wrData,
  input  logic              io_rd0ReqValid,
  output logic              io_rd0ReqReady,
  input  logic [ADDR_W-1:0] io_rd0Base,
  input  logic [LEN_W-1:0]  io_rd0Len,
  input  logic              io_rd1ReqValid,
  output logic              io_rd1ReqReady,
  input  logic [ADDR_W-1:0] io_rd1Base,
  input  logic [LEN_W-1:0]  io_rd1Len,
  output logic              io_rd0RespValid,
  output logic              io_rd0RespLast,
  output logic              io_rd1RespValid,
  output logic              io_rd1RespLast,
  output logic [DATA_W-1:0] io_rdRespData,
  output logic              io_busy,
  output logic              io_mem_wrEna,
  output logic [ADDR_W-1:0] io_mem_Addr,
  output logic [DATA_W-1:0] io_mem_dataIn,
  input  logic [DATA_W-1:0] io_mem_rdData
);
  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
  state_t state, nextState;
  logic [LEN_W-1:0] count, len;
  logic [ADDR_W-1:0] base;
  logic owner, ptr, starve, respValid, respLast;
  logic anyRd, winner, grantRd, wrAcc;
  // grants are gated by reset so combinational outputs stay 0 while reset is asserted
  always_comb begin
    anyRd = io_rd0ReqValid | io_rd1ReqValid;
    winner = (io_rd0ReqValid & io_rd1ReqValid) ? ptr : io_rd1ReqValid;
    grantRd = reset && state == IDLE && anyRd && (!io_wrReqValid || starve);
    wrAcc = reset && state == IDLE && io_wrReqValid && !grantRd;
    nextState = state == IDLE ? (grantRd ? BURST : IDLE) :
                state == BURST ? (count == len ? DRAIN : BURST) : IDLE;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      len <= '0;
      base <= '0;
      owner <= 1'b0;
      ptr <= 1'b0;
      starve <= 1'b0;
      respValid <= 1'b0;
      respLast <= 1'b0;
    end else begin
      state <= nextState;
      count <= (state == BURST && count != len) ? count + 1'b1 : '0;
      respValid <= state == BURST;
      respLast <= state == BURST && count == len;
      if (wrAcc && anyRd) starve <= 1'b1;
      if (grantRd) begin
        starve <= 1'b0;
        ptr <= !winner;
        owner <= winner;
        base <= winner ? io_rd1Base : io_rd0Base;
        len <= winner ? io_rd1Len : io_rd0Len;
      end
    end
  end
  assign io_wrReqReady = wrAcc;
  assign io_rd0ReqReady = grantRd && !winner;
  assign io_rd1ReqReady = grantRd && winner;
  assign io_busy = state != IDLE;
  assign io_mem_wrEna = wrAcc;
  assign io_mem_Addr = wrAcc ? io_wrAddr : state == BURST ? base + ADDR_W'(count) : '0;
  assign io_mem_dataIn = wrAcc ? io_wrData : '0;
  assign io_rd0RespValid = respValid && !owner;
  assign io_rd1RespValid = respValid && owner;
  assign io_rd0RespLast = respLast && !owner;
  assign io_rd1RespLast = respLast && owner;
  assign io_rdRespData = respValid ? io_mem_rdData : '0;
endmodule

// File: tb/tb_datapoint_memory_arbiter.sv
// tb_datapoint_memory_arbiter: directed and randomized checks of the datapoint memory arbiter against a transaction-level model
module tb_datapoint_memory_arbiter;
  localparam int DW = 18;
  localparam int AW = 10;
  localparam int LW = 8;
  localparam int OW = 9 + AW + 2 * DW;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic wrValid = 1'b0, rd0Valid = 1'b0, rd1Valid = 1'b0;
  logic [AW-1:0] wrAddr = '0, rd0Base = '0, rd1Base = '0;
  logic [DW-1:0] wrData = '0;
  logic [LW-1:0] rd0Len = '0, rd1Len = '0;
  logic io_wrReqReady, io_rd0ReqReady, io_rd1ReqReady;
  logic io_rd0RespValid, io_rd0RespLast, io_rd1RespValid, io_rd1RespLast;
  logic [DW-1:0] io_rdRespData, io_mem_dataIn;
  logic io_busy, io_mem_wrEna;
  logic [AW-1:0] io_mem_Addr;
  logic [DW-1:0] memRd = '0;
  logic [DW-1:0] memArr [0:(1<<AW)-1];
  logic [OW-1:0] obs;
  int vecs = 0;
  int errs = 0;

  datapoint_memory_arbiter #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clock(clock), .reset(reset),
    .io_wrReqValid(wrValid), .io_wrReqReady(io_wrReqReady), .io_wrAddr(wrAddr), .io_wrData(wrData),
    .io_rd0ReqValid(rd0Valid), .io_rd0ReqReady(io_rd0ReqReady), .io_rd0Base(rd0Base), .io_rd0Len(rd0Len),
    .io_rd1ReqValid(rd1Valid), .io_rd1ReqReady(io_rd1ReqReady), .io_rd1Base(rd1Base), .io_rd1Len(rd1Len),
    .io_rd0RespValid(io_rd0RespValid), .io_rd0RespLast(io_rd0RespLast),
    .io_rd1RespValid(io_rd1RespValid), .io_rd1RespLast(io_rd1RespLast),
    .io_rdRespData(io_rdRespData), .io_busy(io_busy),
    .io_mem_wrEna(io_mem_wrEna), .io_mem_Addr(io_mem_Addr), .io_mem_dataIn(io_mem_dataIn), .io_mem_rdData(memRd)
  );

  always #5 clock = ~clock;

  // memory with one-cycle read latency
  always @(posedge clock) begin
    if (io_mem_wrEna) memArr[io_mem_Addr] <= io_mem_dataIn;
    memRd <= memArr[io_mem_Addr];
  end

  assign obs = {io_wrReqReady, io_rd0ReqReady, io_rd1ReqReady, io_rd0RespValid, io_rd0RespLast,
                io_rd1RespValid, io_rd1RespLast, io_busy, io_mem_wrEna, io_mem_Addr, io_mem_dataIn, io_rdRespData};

  task automatic drop_all();
    wrValid = 1'b0;
    rd0Valid = 1'b0;
    rd1Valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    drop_all();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wrValid = 1'b1;
    rd0Valid = 1'b1;
    rd1Valid = 1'b1;
    @(negedge clock);
    #1;
    vecs++;
    if (obs !== '0) begin errs++; $display("FAIL reset_outputs got=%h exp=0", obs); end
    @(negedge clock);
    drop_all();
    reset = 1'b1;
    #1;
    vecs++;
    if (obs !== '0) begin errs++; $display("FAIL idle_no_request got=%h exp=0", obs); end
  endtask

  task automatic test_write();
    @(negedge clock);
    wrValid = 1'b1;
    wrAddr = 10'h005;
    wrData = 18'h2A5A5;
    #1;
    vecs++;
    if ({io_wrReqReady, io_mem_wrEna, io_mem_Addr, io_mem_dataIn, io_busy, io_rd0ReqReady, io_rd1ReqReady} !==
        {1'b1, 1'b1, 10'h005, 18'h2A5A5, 3'b000}) begin
      errs++;
      $display("FAIL write got rdy=%b en=%b addr=%h din=%h exp rdy=1 en=1 addr=005 din=2a5a5",
               io_wrReqReady, io_mem_wrEna, io_mem_Addr, io_mem_dataIn);
    end
    @(negedge clock);
    wrValid = 1'b0;
    #1;
    vecs++;
    if (memArr[5] !== 18'h2A5A5) begin errs++; $display("FAIL write_stored got=%h exp=2a5a5", memArr[5]); end
  endtask

  task automatic test_burst_wrap();
    logic [AW-1:0] ea, da;
    logic [DW-1:0] ed;
    @(negedge clock);
    rd0Valid = 1'b1;
    rd0Base = 10'h3FE;
    rd0Len = 8'd3;
    #1;
    vecs++;
    if ({io_rd0ReqReady, io_rd1ReqReady, io_busy, io_mem_wrEna} !== 4'b1000) begin
      errs++;
      $display("FAIL burst_grant got=%b exp=1000", {io_rd0ReqReady, io_rd1ReqReady, io_busy, io_mem_wrEna});
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 0) begin
        rd0Valid = 1'b0;
        rd0Base = 10'h123;
        rd0Len = 8'd0;
      end
      #1;
      ea = (i < 4) ? AW'(1022 + i) : '0;
      da = AW'(1022 + i - 1);
      ed = (i >= 1 && i <= 4) ? memArr[da] : '0;
      vecs++;
      if ({io_busy, io_mem_Addr, io_rd0RespValid, io_rd0RespLast, io_rd1RespValid, io_rd1RespLast, io_rdRespData, io_rd0ReqReady} !==
          {i <= 4, ea, i >= 1 && i <= 4, i == 4, 2'b00, ed, 1'b0}) begin
        errs++;
        $display("FAIL burst_beat%0d got busy=%b addr=%h v=%b l=%b d=%h exp busy=%b addr=%h v=%b l=%b d=%h", i,
                 io_busy, io_mem_Addr, io_rd0RespValid, io_rd0RespLast, io_rdRespData, i <= 4, ea, i >= 1 && i <= 4, i == 4, ed);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] b;
    do_reset();
    @(negedge clock);
    rd0Valid = 1'b1;
    rd1Valid = 1'b1;
    rd0Len = '0;
    rd1Len = '0;
    rd0Base = 10'h010;
    rd1Base = 10'h020;
    for (int g = 0; g < 3; g++) begin
      b = (g == 1) ? 10'h020 : 10'h010;
      #1;
      vecs++;
      if ({io_rd0ReqReady, io_rd1ReqReady, io_busy} !== {g != 1, g == 1, 1'b0}) begin
        errs++;
        $display("FAIL rr_grant%0d got=%b exp=%b", g, {io_rd0ReqReady, io_rd1ReqReady, io_busy}, {g != 1, g == 1, 1'b0});
      end
      @(negedge clock);
      #1;
      vecs++;
      if ({io_busy, io_mem_Addr} !== {1'b1, b}) begin
        errs++;
        $display("FAIL rr_addr%0d got=%h exp=%h", g, io_mem_Addr, b);
      end
      @(negedge clock);
      #1;
      vecs++;
      if ({io_rd0RespValid, io_rd0RespLast, io_rd1RespValid, io_rd1RespLast, io_rdRespData} !==
          {(g == 1) ? 4'b0011 : 4'b1100, memArr[b]}) begin
        errs++;
        $display("FAIL rr_resp%0d got=%b/%h exp=%b/%h", g,
                 {io_rd0RespValid, io_rd0RespLast, io_rd1RespValid, io_rd1RespLast}, io_rdRespData,
                 (g == 1) ? 4'b0011 : 4'b1100, memArr[b]);
      end
      if (g == 2) drop_all();
      @(negedge clock);
    end
  endtask

  task automatic test_starve();
    logic [2:0] exp [5] = '{3'b100, 3'b001, 3'b000, 3'b000, 3'b100};
    logic [DW-1:0] d = DW'($urandom);
    do_reset();
    @(negedge clock);
    wrValid = 1'b1;
    wrAddr = 10'h040;
    wrData = d;
    rd1Valid = 1'b1;
    rd1Base = 10'h050;
    rd1Len = '0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clock);
      #1;
      vecs++;
      if ({io_wrReqReady, io_rd0ReqReady, io_rd1ReqReady} !== exp[i]) begin
        errs++;
        $display("FAIL starve_cyc%0d got=%b exp=%b", i, {io_wrReqReady, io_rd0ReqReady, io_rd1ReqReady}, exp[i]);
      end
    end
    drop_all();
    @(negedge clock);
    #1;
    vecs++;
    if (memArr[10'h040] !== d) begin errs++; $display("FAIL starve_write_stored got=%h exp=%h", memArr[10'h040], d); end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    @(negedge clock);
    rd0Valid = 1'b1;
    rd0Base = 10'h100;
    rd0Len = 8'd7;
    #1;
    vecs++;
    if (io_rd0ReqReady !== 1'b1) begin errs++; $display("FAIL rst_mid_grant got=%b exp=1", io_rd0ReqReady); end
    @(negedge clock);
    rd0Valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    wrValid = 1'b1;
    rd1Valid = 1'b1;
    #1;
    vecs++;
    if (obs !== '0) begin errs++; $display("FAIL rst_mid_immediate got=%h exp=0", obs); end
    @(negedge clock);
    #1;
    vecs++;
    if (obs !== '0) begin errs++; $display("FAIL rst_mid_held got=%h exp=0", obs); end
    @(negedge clock);
    reset = 1'b1;
    wrValid = 1'b0;
    rd0Valid = 1'b1;
    rd0Len = '0;
    rd1Len = '0;
    #1;
    vecs++;
    if ({io_rd0ReqReady, io_rd1ReqReady, io_busy, io_rd0RespValid, io_rd0RespLast} !== 5'b10000) begin
      errs++;
      $display("FAIL rst_mid_resume got=%b exp=10000",
               {io_rd0ReqReady, io_rd1ReqReady, io_busy, io_rd0RespValid, io_rd0RespLast});
    end
    drop_all();
    repeat (3) @(negedge clock);
  endtask

  task automatic test_midburst_write();
    @(negedge clock);
    rd0Valid = 1'b1;
    rd0Base = 10'h200;
    rd0Len = 8'd2;
    #1;
    vecs++;
    if (io_rd0ReqReady !== 1'b1) begin errs++; $display("FAIL mbw_grant got=%b exp=1", io_rd0ReqReady); end
    @(negedge clock);
    rd0Valid = 1'b0;
    wrValid = 1'b1;
    wrAddr = 10'h201;
    wrData = 18'h12345;
    for (int i = 0; i < 4; i++) begin
      #1;
      vecs++;
      if ({io_wrReqReady, io_mem_wrEna} !== 2'b00) begin
        errs++;
        $display("FAIL mbw_busy%0d got=%b exp=00", i, {io_wrReqReady, io_mem_wrEna});
      end
      @(negedge clock);
    end
    #1;
    vecs++;
    if ({io_wrReqReady, io_mem_wrEna, io_mem_Addr} !== {2'b11, 10'h201}) begin
      errs++;
      $display("FAIL mbw_idle got=%b/%h exp=11/201", {io_wrReqReady, io_mem_wrEna}, io_mem_Addr);
    end
    drop_all();
  endtask

  // transaction-level model: a granted burst of n=len+1 words owns the port for n+1 cycles after the grant,
  // word k goes out on address base+k at grant+1+k and comes back at grant+2+k
  task automatic test_random();
    int cyc = 0, freeAt = 0, bStart = 0, bLen = 0, bBase = 0, rel;
    bit prefRd1 = 0, starved = 0, bOwner = 0;
    bit anyR, g, w, acc, v, last;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [OW-1:0] exp;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      @(negedge clock);
      wrValid = $urandom_range(0, 2) == 0;
      rd0Valid = $urandom_range(0, 2) == 0;
      rd1Valid = $urandom_range(0, 2) == 0;
      wrAddr = AW'($urandom);
      wrData = DW'($urandom);
      rd0Base = AW'($urandom);
      rd1Base = AW'($urandom);
      rd0Len = LW'($urandom_range(0, 9));
      rd1Len = LW'($urandom_range(0, 9));
      #1;
      if (cyc >= freeAt) begin
        anyR = rd0Valid || rd1Valid;
        g = anyR && (!wrValid || starved);
        w = (rd0Valid && rd1Valid) ? prefRd1 : rd1Valid;
        acc = wrValid && !g;
        exp = {acc, g && !w, g && w, 5'b00000, acc, acc ? wrAddr : AW'(0), acc ? wrData : DW'(0), DW'(0)};
        if (acc && anyR) starved = 1;
        if (g) begin
          starved = 0;
          prefRd1 = !w;
          bOwner = w;
          bStart = cyc;
          bBase = w ? int'(rd1Base) : int'(rd0Base);
          bLen = w ? int'(rd1Len) : int'(rd0Len);
          freeAt = cyc + bLen + 3;
        end
      end else begin
        rel = cyc - bStart;
        v = rel >= 2 && rel <= bLen + 2;
        last = rel == bLen + 2;
        ea = (rel >= 1 && rel <= bLen + 1) ? AW'(bBase + rel - 1) : AW'(0);
        ed = v ? memArr[AW'(bBase + rel - 2)] : DW'(0);
        exp = {3'b000, v && !bOwner, last && !bOwner, v && bOwner, last && bOwner, 1'b1, 1'b0, ea, DW'(0), ed};
      end
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp); end
      cyc++;
    end
    drop_all();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) memArr[i] = DW'($urandom);
    test_reset();
    test_write();
    test_burst_wrap();
    test_round_robin();
    test_starve();
    test_reset_midburst();
    test_midburst_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
